boton_eventos: RTL

BOTON_EVENTOS -- requirements
Module: boton_eventos

---
 rtl/boton_eventos.sv | 127 ++++++++++++
 1 files changed

// File: rtl/boton_eventos.sv
// Button event generator: one press pulse, timed auto-repeat pulses while the
// button stays down, a release pulse, and a saturating count of repeats.
// All outputs are registered; estado_dbg exposes the FSM state for observation.
module boton_eventos #(
   parameter int DELAY_INICIAL = 5000,
   parameter int PERIODO_REPET = 1000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Nivel,
   input  logic       Habilitar,
   output logic       Pulso,
   output logic       Liberado,
   output logic       Repitiendo,
   output logic [7:0] Conteo_Rep,
   output logic [1:0] estado_dbg
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ESPERA = 2'd1,
      REPITE = 2'd2
   } estado_t;

   // The counter starts at 0 on the cycle of a pulse, so the deadline is N-1.
   localparam logic [13:0] LIM_ESPERA = 14'(DELAY_INICIAL - 1);
   localparam logic [13:0] LIM_REPITE = 14'(PERIODO_REPET - 1);

   estado_t     estado_q, estado_d;
   logic [13:0] cuenta_q, cuenta_d;
   logic        nivel_prev_q, nivel_prev_d;
   logic        pulso_q, pulso_d;
   logic        liberado_q, liberado_d;
   logic        repitiendo_q, repitiendo_d;
   logic [7:0]  conteo_q, conteo_d;
   logic        flanco;
   logic [7:0]  conteo_inc;

   assign flanco     = Nivel & ~nivel_prev_q;
   // Repeat count saturates at 255 instead of wrapping.
   assign conteo_inc = (conteo_q == 8'hFF) ? conteo_q : conteo_q + 8'd1;

   // Next-state and next-output logic; disable beats release, release beats a deadline.
   always_comb begin
      estado_d     = estado_q;
      cuenta_d     = cuenta_q;
      nivel_prev_d = Nivel;
      pulso_d      = 1'b0;
      liberado_d   = 1'b0;
      conteo_d     = conteo_q;
      if (!Habilitar) begin
         estado_d = REPOSO;
         cuenta_d = '0;
      end else begin
         case (estado_q)
            REPOSO: begin
               cuenta_d = '0;
               if (flanco) begin
                  pulso_d  = 1'b1;
                  conteo_d = '0;
                  estado_d = ESPERA;
               end
            end
            ESPERA: begin
               if (!Nivel) begin
                  liberado_d = 1'b1;
                  cuenta_d   = '0;
                  estado_d   = REPOSO;
               end else if (cuenta_q == LIM_ESPERA) begin
                  pulso_d  = 1'b1;
                  cuenta_d = '0;
                  conteo_d = conteo_inc;
                  estado_d = REPITE;
               end else begin
                  cuenta_d = cuenta_q + 14'd1;
               end
            end
            REPITE: begin
               if (!Nivel) begin
                  liberado_d = 1'b1;
                  cuenta_d   = '0;
                  estado_d   = REPOSO;
               end else if (cuenta_q == LIM_REPITE) begin
                  pulso_d  = 1'b1;
                  cuenta_d = '0;
                  conteo_d = conteo_inc;
               end else begin
                  cuenta_d = cuenta_q + 14'd1;
               end
            end
            default: begin
               estado_d = REPOSO;
               cuenta_d = '0;
            end
         endcase
      end
      repitiendo_d = (estado_d == REPITE);
   end

   // State and output registers; nivel_prev resets high so a held button is not a press.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q     <= REPOSO;
         cuenta_q     <= '0;
         nivel_prev_q <= 1'b1;
         pulso_q      <= 1'b0;
         liberado_q   <= 1'b0;
         repitiendo_q <= 1'b0;
         conteo_q     <= '0;
      end else begin
         estado_q     <= estado_d;
         cuenta_q     <= cuenta_d;
         nivel_prev_q <= nivel_prev_d;
         pulso_q      <= pulso_d;
         liberado_q   <= liberado_d;
         repitiendo_q <= repitiendo_d;
         conteo_q     <= conteo_d;
      end
   end

   assign Pulso      = pulso_q;
   assign Liberado   = liberado_q;
   assign Repitiendo = repitiendo_q;
   assign Conteo_Rep = conteo_q;
   assign estado_dbg = estado_q;

endmodule
